// File: rtl/bitstream_packer_if.sv
// bitstream_packer_if: code input handshake and encoded-RAM write port of bitstream_packer
interface bitstream_packer_if #(
  parameter int CODE_W = 24,
  parameter int ADDR_W = 13
);
  logic              en_i;
  logic [CODE_W-1:0] code_i;
  logic [5:0]        len_i;
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic [31:0]       word_o;
  logic              word_we_o;
  logic [ADDR_W-1:0] word_addr_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              done_o;
  logic              overflow_o;
  modport master (
    output en_i, code_i, len_i, valid_i, flush_i,
    input  ready_o, word_o, word_we_o, word_addr_o, word_cnt_o, done_o, overflow_o
  );
  modport slave (
    input  en_i, code_i, len_i, valid_i, flush_i,
    output ready_o, word_o, word_we_o, word_addr_o, word_cnt_o, done_o, overflow_o
  );
endinterface

// File: rtl/bitstream_packer.sv
// bitstream_packer: packs variable-length codes MSB-first into 32-bit RAM words.
// Define PACK_ONE_PAD_EN to pad the final flushed word with 1s instead of 0s.
module bitstream_packer #(
  parameter int CODE_W    = 24,
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 2406
) (
  input logic clk_i,
  input logic rst_i,
  bitstream_packer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [5:0]      CW   = 6'(CODE_W);
  localparam logic [6:0]      RMAX = 7'(64 - CODE_W);
  localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(MAX_WORDS);
  state_t            state_q, state_d;
  logic [63:0]       acc_q, acc_d, shifted, aligned;
  logic [6:0]        cnt_q, cnt_d, scnt;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [31:0]       word_q, word_d, pad_bits;
  logic              we_q, we_d, ovf_q, ovf_d;
  logic [5:0]        len_c;
  logic [CODE_W-1:0] code_m;
  logic              active, full, pad, emit, fits, accept, start, ready, done;
  assign active  = (state_q == RUN || state_q == FLUSH) && bus.en_i;
  assign full    = active && cnt_q >= 7'd32;
  assign pad     = active && state_q == FLUSH && cnt_q != 7'd0 && cnt_q < 7'd32;
  assign emit    = full || pad;
  assign fits    = {1'b0, addr_q} < MAXW;
  assign accept  = bus.valid_i && ready;
  assign start   = state_q == IDLE && bus.en_i;
  assign len_c   = bus.len_i > CW ? CW : bus.len_i;
  assign code_m  = bus.code_i & ~({CODE_W{1'b1}} << len_c);
  assign aligned = {code_m, {(64-CODE_W){1'b0}}} << (CW - len_c);
  // a same-cycle emit shifts the word out first, so the new code lands at cnt-32
  assign shifted = emit ? {acc_q[31:0], 32'b0} : acc_q;
  assign scnt    = full ? cnt_q - 7'd32 : pad ? 7'd0 : cnt_q;
`ifdef PACK_ONE_PAD_EN
  assign pad_bits = pad ? 32'hFFFF_FFFF >> cnt_q[4:0] : 32'b0;
`else
  assign pad_bits = 32'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.en_i ? RUN : IDLE;
      RUN:     state_d = !bus.en_i ? IDLE : bus.flush_i ? FLUSH : RUN;
      FLUSH:   state_d = !bus.en_i ? IDLE : cnt_q == 7'd0 ? DONE : FLUSH;
      default: state_d = bus.en_i ? DONE : IDLE;
    endcase
  end
  always_comb begin
    ready = state_q == RUN && cnt_q <= RMAX && !bus.flush_i;
    done  = state_q == DONE;
  end
  always_comb begin
    acc_d   = state_q == IDLE ? 64'b0 : accept ? shifted | (aligned >> scnt) : shifted;
    cnt_d   = state_q == IDLE ? 7'd0 : scnt + (accept ? {1'b0, len_c} : 7'd0);
    we_d    = emit && fits;
    word_d  = we_d ? acc_q[63:32] | pad_bits : word_q;
    addr_d  = start ? '0 : we_d ? addr_q + 1'b1 : addr_q;
    waddr_d = start ? '0 : we_d ? addr_q : waddr_q;
    wcnt_d  = start ? '0 : we_d ? wcnt_q + 1'b1 : wcnt_q;
    ovf_d   = start ? 1'b0 : ovf_q || (emit && !fits);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end
  assign bus.ready_o     = ready;
  assign bus.done_o      = done;
  assign bus.word_o      = word_q;
  assign bus.word_we_o   = we_q;
  assign bus.word_addr_o = waddr_q;
  assign bus.word_cnt_o  = wcnt_q;
  assign bus.overflow_o  = ovf_q;
endmodule
